adc_spi_responder: RTL and testbench

SPI slave that emulates an 8-channel, 12-bit serial ADC, the device end of the ADC SPI link used on the IMU board. It responds to the ADC controller's CS_n/SCLK/DIN frames and shifts the 12-bit value of the addressed channel onto DOUT. Channel values come from parallel inputs. It serves as a hardware-in-loop stand-in for the physical ADC, and as a bench model for the ADC controller. All SPI inputs are asynchronous to iCLK and are oversampled.

---
 rtl/adc_spi_pkg.sv | 12 +
 rtl/adc_spi_responder_sync_edge.sv | 27 ++
 rtl/adc_spi_responder.sv | 92 +++++++++
 tb/tb_adc_spi_responder.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/adc_spi_pkg.sv
// adc_spi_pkg: frame geometry, state encoding and frame-word helper for the ADC SPI responder
package adc_spi_pkg;
   localparam int FRAME_BITS      = 16;
   localparam int LEAD_ZEROS      = 4;
   localparam int DATA_BITS       = 12;
   localparam int NUM_CH          = 8;
   localparam int ADDR_RISE_FIRST = 2;
   typedef enum logic {IDLE, ACTIVE} state_t;
   function automatic logic [FRAME_BITS-1:0] frame_word(input logic [NUM_CH*DATA_BITS-1:0] d, input logic [2:0] c);
      return {{LEAD_ZEROS{1'b0}}, d[c*DATA_BITS +: DATA_BITS]};
   endfunction
endpackage

// File: rtl/adc_spi_responder_sync_edge.sv
// sync_edge: multi-flop synchronizer with one-cycle rise/fall pulses on the synchronized level
module sync_edge
   import adc_spi_pkg::*;
#(
   parameter int   SYNC_STAGES = 2,
   parameter logic RESET_VAL   = 1'b1
) (
   input  logic iCLK,
   input  logic iRST,
   input  logic iD,
   output logic oRISE,
   output logic oFALL
);
   logic [SYNC_STAGES-1:0] sync;
   logic prev;
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         sync <= {SYNC_STAGES{RESET_VAL}};
         prev <= RESET_VAL;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], iD};
         prev <= sync[SYNC_STAGES-1];
      end
   end
   assign oRISE = sync[SYNC_STAGES-1] & ~prev;
   assign oFALL = ~sync[SYNC_STAGES-1] & prev;
endmodule

// File: rtl/adc_spi_responder.sv
// adc_spi_responder: SPI slave emulating an 8-channel 12-bit ADC, data taken from parallel inputs
module adc_spi_responder
   import adc_spi_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic                        iCLK,
   input  logic                        iRST,
   input  logic                        iSCLK,
   input  logic                        iCS_n,
   input  logic                        iDIN,
   output logic                        oDOUT,
   output logic                        oDOUT_EN,
   input  logic [NUM_CH*DATA_BITS-1:0] iCH_DATA,
   output logic [2:0]                  oCUR_CH,
   output logic                        oFRAME_DONE,
   output logic                        oFRAME_ERR
);
   localparam logic [4:0] CNT_FULL = 5'(FRAME_BITS);
   localparam logic [4:0] CNT_LAST = 5'(FRAME_BITS - 1);
   localparam logic [4:0] ADDR_LO  = 5'(ADDR_RISE_FIRST);
   localparam logic [4:0] ADDR_HI  = 5'(ADDR_RISE_FIRST + 2);
   state_t state, state_nxt;
   logic sclk_rise, sclk_fall, cs_rise, cs_fall, din;
   logic [SYNC_STAGES-1:0] din_sync;
   logic [4:0] rise_cnt;
   logic [FRAME_BITS-1:0] sh;
   logic [2:0] addr, ch;
   logic frame_done, frame_err;
   sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sclk (
      .iCLK(iCLK), .iRST(iRST), .iD(iSCLK), .oRISE(sclk_rise), .oFALL(sclk_fall)
   );
   sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs (
      .iCLK(iCLK), .iRST(iRST), .iD(iCS_n), .oRISE(cs_rise), .oFALL(cs_fall)
   );
   always_ff @(posedge iCLK) begin
      if (iRST) din_sync <= '0;
      else din_sync <= {din_sync[SYNC_STAGES-2:0], iDIN};
   end
   assign din = din_sync[SYNC_STAGES-1];
   always_ff @(posedge iCLK) begin
      if (iRST) state <= IDLE;
      else state <= state_nxt;
   end
   always_comb begin
      state_nxt = (state == IDLE) ? (cs_fall ? ACTIVE : IDLE) : (cs_rise ? IDLE : ACTIVE);
   end
   // CS_n rise takes priority over any coincident SCLK edge
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         rise_cnt   <= '0;
         sh         <= '0;
         addr       <= '0;
         ch         <= '0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         if (state == IDLE) begin
            if (cs_fall) begin
               sh       <= frame_word(iCH_DATA, ch);
               rise_cnt <= '0;
            end
         end else if (cs_rise) begin
            frame_err <= (rise_cnt != '0) && (rise_cnt != CNT_FULL);
         end else if (sclk_rise && rise_cnt < CNT_FULL) begin
            rise_cnt <= rise_cnt + 5'd1;
            if (rise_cnt >= ADDR_LO && rise_cnt <= ADDR_HI) addr <= {addr[1:0], din};
            if (rise_cnt == CNT_LAST) begin
               frame_done <= 1'b1;
               ch         <= addr;
            end
         end else if (sclk_fall) begin
            // a fall after the 16th rise opens the next frame in continuous-CS mode
            if (rise_cnt == CNT_FULL) begin
               sh       <= frame_word(iCH_DATA, ch);
               rise_cnt <= '0;
            end else begin
               sh <= {sh[FRAME_BITS-2:0], 1'b0};
            end
         end
      end
   end
   always_comb begin
      oDOUT_EN    = (state == ACTIVE);
      oDOUT       = (state == ACTIVE) & sh[FRAME_BITS-1];
      oCUR_CH     = ch;
      oFRAME_DONE = frame_done;
      oFRAME_ERR  = frame_err;
   end
endmodule

// File: tb/tb_adc_spi_responder.sv
// tb_adc_spi_responder: directed SPI-master stimulus with hand-computed expected bitstreams
module tb_adc_spi_responder;
   logic iCLK, iRST, iSCLK, iCS_n, iDIN;
   logic oDOUT, oDOUT_EN, oFRAME_DONE, oFRAME_ERR;
   logic [95:0] ch_data;
   logic [2:0] oCUR_CH;
   logic [15:0] rx;
   int errors, checks, done_cnt, err_cnt;

   adc_spi_responder #(.SYNC_STAGES(2)) dut (
      .iCLK(iCLK), .iRST(iRST), .iSCLK(iSCLK), .iCS_n(iCS_n), .iDIN(iDIN),
      .oDOUT(oDOUT), .oDOUT_EN(oDOUT_EN), .iCH_DATA(ch_data), .oCUR_CH(oCUR_CH),
      .oFRAME_DONE(oFRAME_DONE), .oFRAME_ERR(oFRAME_ERR)
   );

   initial iCLK = 1'b0;
   always #5 iCLK = ~iCLK;

   always @(negedge iCLK) begin
      if (oFRAME_DONE) done_cnt++;
      if (oFRAME_ERR) err_cnt++;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge iCLK);
   endtask

   task automatic set_ch(input int n, input logic [11:0] v);
      ch_data[n*12 +: 12] = v;
   endtask

   task automatic start_cs();
      iSCLK = 1'b0;
      tick(4);
      iCS_n = 1'b0;
   endtask

   task automatic end_cs();
      tick(4);
      iCS_n = 1'b1;
      tick(8);
   endtask

   // DOUT is captured just before each rise, i.e. at the end of the low phase
   task automatic shift(input logic [2:0] a, input int p, input int r0, input int r1, input bit last_fall);
      for (int r = r0; r <= r1; r++) begin
         iDIN = (r == 3) ? a[2] : (r == 4) ? a[1] : (r == 5) ? a[0] : 1'b0;
         tick(p / 2);
         rx[16-r] = oDOUT;
         iSCLK = 1'b1;
         tick(p - p / 2);
         if (r < r1 || last_fall) iSCLK = 1'b0;
      end
   endtask

   task automatic full_frame(input logic [2:0] a, input int p);
      start_cs();
      shift(a, p, 1, 16, 1'b0);
      end_cs();
   endtask

   task automatic test_reset();
      iRST = 1'b1; iCS_n = 1'b1; iSCLK = 1'b1; iDIN = 1'b0;
      tick(4);
      checks++; if (oDOUT_EN !== 1'b0) begin errors++; $display("FAIL rst_en: got %b expected 0", oDOUT_EN); end
      checks++; if (oDOUT !== 1'b0) begin errors++; $display("FAIL rst_dout: got %b expected 0", oDOUT); end
      checks++; if (oCUR_CH !== 3'd0) begin errors++; $display("FAIL rst_ch: got %0d expected 0", oCUR_CH); end
      iRST = 1'b0;
      tick(6);
      checks++; if (done_cnt !== 0 || err_cnt !== 0) begin errors++; $display("FAIL rst_pulses: got done=%0d err=%0d expected 0/0", done_cnt, err_cnt); end
   endtask

   task automatic test_basic();
      int d0;
      d0 = done_cnt;
      start_cs();
      tick(4);
      checks++; if (oDOUT_EN !== 1'b1) begin errors++; $display("FAIL basic_en: got %b expected 1", oDOUT_EN); end
      shift(3'b101, 8, 1, 16, 1'b0);
      end_cs();
      checks++; if (rx !== 16'h0A5C) begin errors++; $display("FAIL basic_f1_dout: got %h expected 0a5c", rx); end
      checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL basic_f1_done: got %0d expected 1", done_cnt - d0); end
      checks++; if (oCUR_CH !== 3'd5) begin errors++; $display("FAIL basic_f1_ch: got %0d expected 5", oCUR_CH); end
      checks++; if (oDOUT_EN !== 1'b0) begin errors++; $display("FAIL basic_idle_en: got %b expected 0", oDOUT_EN); end
      full_frame(3'b010, 8);
      checks++; if (rx !== 16'h03F1) begin errors++; $display("FAIL basic_f2_dout: got %h expected 03f1", rx); end
      checks++; if (oCUR_CH !== 3'd2) begin errors++; $display("FAIL basic_f2_ch: got %0d expected 2", oCUR_CH); end
   endtask

   task automatic test_continuous();
      int d0, e0;
      d0 = done_cnt; e0 = err_cnt;
      start_cs();
      shift(3'd7, 8, 1, 16, 1'b1);
      checks++; if (rx !== 16'h02C7) begin errors++; $display("FAIL cont_f1_dout: got %h expected 02c7", rx); end
      shift(3'd0, 8, 1, 16, 1'b1);
      checks++; if (rx !== 16'h0E18) begin errors++; $display("FAIL cont_f2_dout: got %h expected 0e18", rx); end
      shift(3'd7, 8, 1, 16, 1'b0);
      checks++; if (rx !== 16'h0A5C) begin errors++; $display("FAIL cont_f3_dout: got %h expected 0a5c", rx); end
      end_cs();
      checks++; if (done_cnt - d0 !== 3) begin errors++; $display("FAIL cont_done: got %0d expected 3", done_cnt - d0); end
      checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL cont_err: got %0d expected 0", err_cnt - e0); end
      checks++; if (oCUR_CH !== 3'd7) begin errors++; $display("FAIL cont_ch: got %0d expected 7", oCUR_CH); end
   endtask

   task automatic test_abort();
      int d0, e0;
      d0 = done_cnt; e0 = err_cnt;
      start_cs();
      shift(3'd3, 8, 1, 9, 1'b0);
      end_cs();
      checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL abort_err: got %0d expected 1", err_cnt - e0); end
      checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL abort_done: got %0d expected 0", done_cnt - d0); end
      checks++; if (oCUR_CH !== 3'd7) begin errors++; $display("FAIL abort_ch: got %0d expected 7", oCUR_CH); end
      checks++; if (oDOUT_EN !== 1'b0) begin errors++; $display("FAIL abort_en: got %b expected 0", oDOUT_EN); end
      full_frame(3'd1, 8);
      checks++; if (rx !== 16'h0E18) begin errors++; $display("FAIL abort_next_dout: got %h expected 0e18", rx); end
      checks++; if (oCUR_CH !== 3'd1) begin errors++; $display("FAIL abort_next_ch: got %0d expected 1", oCUR_CH); end
   endtask

   task automatic test_reset_mid();
      int e0;
      start_cs();
      shift(3'd4, 8, 1, 6, 1'b0);
      iRST = 1'b1;
      tick(2);
      checks++; if ({oDOUT, oDOUT_EN, oFRAME_DONE, oFRAME_ERR} !== 4'b0) begin errors++; $display("FAIL midrst_outs: got %b expected 0000", {oDOUT, oDOUT_EN, oFRAME_DONE, oFRAME_ERR}); end
      checks++; if (oCUR_CH !== 3'd0) begin errors++; $display("FAIL midrst_ch: got %0d expected 0", oCUR_CH); end
      iCS_n = 1'b1;
      tick(4);
      iRST = 1'b0;
      e0 = err_cnt;
      tick(6);
      full_frame(3'd6, 8);
      checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL midrst_err: got %0d expected 0", err_cnt - e0); end
      checks++; if (rx !== 16'h0A5C) begin errors++; $display("FAIL midrst_next_dout: got %h expected 0a5c", rx); end
      checks++; if (oCUR_CH !== 3'd6) begin errors++; $display("FAIL midrst_next_ch: got %0d expected 6", oCUR_CH); end
   endtask

   task automatic test_snapshot();
      start_cs();
      shift(3'd3, 8, 1, 8, 1'b1);
      set_ch(6, 12'hFFF);
      shift(3'd3, 8, 9, 16, 1'b0);
      end_cs();
      set_ch(6, 12'h123);
      checks++; if (rx !== 16'h0123) begin errors++; $display("FAIL snap_dout: got %h expected 0123", rx); end
      checks++; if (oCUR_CH !== 3'd3) begin errors++; $display("FAIL snap_ch: got %0d expected 3", oCUR_CH); end
   endtask

   task automatic test_ratio();
      int ps[3] = '{8, 13, 32};
      for (int i = 0; i < 3; i++) begin
         full_frame(3'd3, ps[i]);
         checks++; if (rx !== 16'h09B7) begin errors++; $display("FAIL ratio_%0d_dout: got %h expected 09b7", ps[i], rx); end
         checks++; if (oCUR_CH !== 3'd3) begin errors++; $display("FAIL ratio_%0d_ch: got %0d expected 3", ps[i], oCUR_CH); end
      end
   endtask

   initial begin
      errors = 0; checks = 0; done_cnt = 0; err_cnt = 0; rx = '0;
      iRST = 1'b1; iCS_n = 1'b1; iSCLK = 1'b1; iDIN = 1'b0;
      ch_data = '0;
      set_ch(0, 12'hA5C); set_ch(1, 12'h456); set_ch(2, 12'h2C7); set_ch(3, 12'h9B7);
      set_ch(4, 12'h7AD); set_ch(5, 12'h3F1); set_ch(6, 12'h123); set_ch(7, 12'hE18);
      test_reset();
      test_basic();
      test_continuous();
      test_abort();
      test_reset_mid();
      test_snapshot();
      test_ratio();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
